// File: rtl/data_memory_responder.sv
// Load/store responder with one outstanding request; the response is valid LATENCY cycles after accept and is held until resp_ready.
// Define BYTE_STROBE_EN to make stores honour req_be; otherwise every store writes the full word.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module data_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [`WORD_SIZE-1:0] req_addr,
  input  logic [`WORD_SIZE-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [`WORD_SIZE-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [`WORD_SIZE-1:0] r_addr;
  logic [`WORD_SIZE-1:0] r_wdata;
  logic [3:0]            r_be;
  logic [`WORD_SIZE-1:0] r_rdata;
  logic                  r_err;
  logic [`WORD_SIZE-1:0] r_mem [DEPTH] = '{default: '0};

  logic                  w_accept;
  logic                  w_exec;
  logic                  w_err;
  logic [AW-1:0]         w_idx;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_exec   = (r_state == WAIT) && (r_cnt == '0) && rst;
  assign w_idx    = r_addr[AW+1:2];
  assign w_err    = (r_addr[1:0] != 2'b00) || ((r_addr >> (AW + 2)) != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = WAIT;
      WAIT:    if (r_cnt == '0) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (r_state == IDLE) && rst;
    resp_valid = (r_state == RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= CW'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_exec) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? '0 : r_mem[w_idx];
      end
    end
  end

  // Request capture needs no reset: it is only consumed after an accept
  always_ff @(posedge clk) begin
    if (rst && w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

`ifdef BYTE_STROBE_EN
  always_ff @(posedge clk) begin
    if (w_exec && !w_err && r_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end
`else
  logic w_unused_be;
  assign w_unused_be = ^r_be;

  always_ff @(posedge clk) begin
    if (w_exec && !w_err && r_we) r_mem[w_idx] <= r_wdata;
  end
`endif

endmodule
